// File: rtl/axi_wdata_packer.sv
// axi_wdata_packer: accepts upstream AXI write bursts of 16-bit beats, packs them
// into 128-bit words with byte strobes, issues them as a DDR AXI4 write burst and
// forwards the DDR write response back upstream. One burst is in flight at a time.
module axi_wdata_packer #(
    parameter int ADDR_W = 32,
    parameter int ID_W   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] s_awaddr,
    input  logic [3:0]        s_awlen,
    input  logic [ID_W-1:0]   s_awid,
    input  logic              s_awvalid,
    output logic              s_awready,
    input  logic [15:0]       s_wdata,
    input  logic [1:0]        s_wstrb,
    input  logic              s_wvalid,
    output logic              s_wready,
    output logic [ID_W-1:0]   s_bid,
    output logic [1:0]        s_bresp,
    output logic              s_bvalid,
    input  logic              s_bready,
    output logic [ADDR_W-1:0] m_awaddr,
    output logic [3:0]        m_awlen,
    output logic              m_awvalid,
    input  logic              m_awready,
    output logic [127:0]      m_wdata,
    output logic [15:0]       m_wstrb,
    output logic              m_wlast,
    output logic              m_wvalid,
    input  logic              m_wready,
    input  logic [1:0]        m_bresp,
    input  logic              m_bvalid,
    output logic              m_bready
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    state_t          state_r;
    state_t          state_s;
    logic [ID_W-1:0] id_r;
    logic [3:0]      len_r;
    logic [4:0]      beat_cnt_r;      // upstream beats accepted so far (0..16)
    logic [2:0]      lane_r;          // 16-bit lane the next beat lands in
    logic [127:0]    buf_data_r;
    logic [15:0]     buf_strb_r;

    logic            aw_fire_s;
    logic            w_fire_s;
    logic            mw_fire_s;
    logic            mb_fire_s;
    logic            sb_fire_s;
    logic            last_beat_s;
    logic            flush_s;
    logic            room_s;
    logic [127:0]    merge_data_s;
    logic [15:0]     merge_strb_s;
    logic            addr_bit0_unused_s;

    // Beat addresses are halfword aligned, so the byte-select bit carries no information.
    assign addr_bit0_unused_s = s_awaddr[0];

    assign aw_fire_s   = s_awvalid & s_awready;
    assign w_fire_s    = s_wvalid & s_wready;
    assign mw_fire_s   = m_wvalid & m_wready;
    assign mb_fire_s   = m_bvalid & m_bready;
    assign sb_fire_s   = s_bvalid & s_bready;
    assign room_s      = (beat_cnt_r <= {1'b0, len_r});
    assign last_beat_s = (beat_cnt_r == {1'b0, len_r});
    assign flush_s     = (lane_r == 3'd7) | last_beat_s;

    // Pack buffer with the incoming beat dropped into its lane.
    always_comb begin
        merge_data_s = buf_data_r;
        merge_strb_s = buf_strb_r;
        merge_data_s[{lane_r, 4'b0000} +: 16] = s_wdata;
        merge_strb_s[{lane_r, 1'b0} +: 2]     = s_wstrb;
    end

    // Ready outputs: decoded from the state, forced low while reset is asserted.
    always_comb begin
        s_awready = 1'b0;
        s_wready  = 1'b0;
        m_bready  = 1'b0;
        if (reset) begin
            s_awready = 1'b0;
            s_wready  = 1'b0;
            m_bready  = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: s_awready = 1'b1;
                // A beat may only be taken when its word (if it completes one) has a free slot.
                ST_DATA: s_wready  = room_s & (~m_wvalid | m_wready);
                ST_RESP: m_bready  = ~s_bvalid;
                default: s_awready = 1'b0;
            endcase
        end
    end

    // Next-state decode for the burst sequencer.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (aw_fire_s) begin
                    state_s = ST_ADDR;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ADDR: begin
                if (m_awvalid & m_awready) begin
                    state_s = ST_DATA;
                end else begin
                    state_s = ST_ADDR;
                end
            end
            ST_DATA: begin
                if (mw_fire_s & m_wlast) begin
                    state_s = ST_RESP;
                end else begin
                    state_s = ST_DATA;
                end
            end
            ST_RESP: begin
                if (sb_fire_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RESP;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Burst sequencer state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // DDR address channel: derive aligned address and word count from the upstream burst.
    always_ff @(posedge clk) begin
        if (reset) begin
            id_r      <= '0;
            len_r     <= 4'd0;
            m_awaddr  <= '0;
            m_awlen   <= 4'd0;
            m_awvalid <= 1'b0;
        end else if (aw_fire_s) begin
            id_r      <= s_awid;
            len_r     <= s_awlen;
            m_awaddr  <= {s_awaddr[ADDR_W-1:4], 4'h0};
            // Last lane touched, divided by 8 lanes per word, gives DDR beats minus one.
            m_awlen   <= 4'(({2'b00, s_awaddr[3:1]} + {1'b0, s_awlen}) >> 3);
            m_awvalid <= 1'b1;
        end else if (m_awvalid & m_awready) begin
            m_awvalid <= 1'b0;
        end
    end

    // Pack upstream beats into lanes and hand completed words to the DDR W channel.
    always_ff @(posedge clk) begin
        if (reset) begin
            beat_cnt_r <= 5'd0;
            lane_r     <= 3'd0;
            buf_data_r <= 128'd0;
            buf_strb_r <= 16'd0;
            m_wdata    <= 128'd0;
            m_wstrb    <= 16'd0;
            m_wlast    <= 1'b0;
            m_wvalid   <= 1'b0;
        end else if (aw_fire_s) begin
            beat_cnt_r <= 5'd0;
            lane_r     <= s_awaddr[3:1];
            buf_data_r <= 128'd0;
            buf_strb_r <= 16'd0;
        end else if (w_fire_s) begin
            beat_cnt_r <= beat_cnt_r + 5'd1;
            lane_r     <= lane_r + 3'd1;
            if (flush_s) begin
                // Reload in the same cycle as a handshake keeps the stream back-to-back.
                m_wdata    <= merge_data_s;
                m_wstrb    <= merge_strb_s;
                m_wlast    <= last_beat_s;
                m_wvalid   <= 1'b1;
                buf_data_r <= 128'd0;
                buf_strb_r <= 16'd0;
            end else begin
                buf_data_r <= merge_data_s;
                buf_strb_r <= merge_strb_s;
                if (mw_fire_s) begin
                    m_wvalid <= 1'b0;
                end
            end
        end else if (mw_fire_s) begin
            m_wvalid <= 1'b0;
        end
    end

    // Response path: capture the DDR response once and hold it until upstream takes it.
    always_ff @(posedge clk) begin
        if (reset) begin
            s_bid    <= '0;
            s_bresp  <= 2'b00;
            s_bvalid <= 1'b0;
        end else if (mb_fire_s) begin
            s_bid    <= id_r;
            s_bresp  <= m_bresp;
            s_bvalid <= 1'b1;
        end else if (sb_fire_s) begin
            s_bvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axi_wdata_packer.sv
// tb_axi_wdata_packer: table-driven directed bursts, hand-written reset sequence and
// random bursts, all checked against a byte-address reference model.
module tb_axi_wdata_packer;

    logic         clk = 1'b0;
    logic         reset;
    logic [31:0]  s_awaddr;
    logic [3:0]   s_awlen;
    logic [3:0]   s_awid;
    logic         s_awvalid;
    logic         s_awready;
    logic [15:0]  s_wdata;
    logic [1:0]   s_wstrb;
    logic         s_wvalid;
    logic         s_wready;
    logic [3:0]   s_bid;
    logic [1:0]   s_bresp;
    logic         s_bvalid;
    logic         s_bready;
    logic [31:0]  m_awaddr;
    logic [3:0]   m_awlen;
    logic         m_awvalid;
    logic         m_awready;
    logic [127:0] m_wdata;
    logic [15:0]  m_wstrb;
    logic         m_wlast;
    logic         m_wvalid;
    logic         m_wready;
    logic [1:0]   m_bresp;
    logic         m_bvalid;
    logic         m_bready;

    always #5 clk = ~clk;

    axi_wdata_packer #(.ADDR_W(32), .ID_W(4)) dut (
        .clk(clk), .reset(reset),
        .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awid(s_awid),
        .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
        .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready)
    );

    typedef struct {
        logic [127:0] d;
        logic [15:0]  s;
        logic         l;
    } word_t;

    typedef struct {
        logic [31:0]  addr;
        int           len;
        logic [3:0]   id;
        logic [1:0]   bresp;
        int           wmode;
        int           bdelay;
        logic [31:0]  exp_awaddr;
        logic [3:0]   exp_awlen;
        int           exp_nw;
        logic [15:0]  exp_strb0;
        logic [15:0]  exp_strbn;
        logic [127:0] exp_data0;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] beat_data [16];
    logic [1:0]  beat_strb [16];
    word_t       obs_q [$];
    logic [31:0] obs_awaddr;
    logic [3:0]  obs_awlen;
    vec_t        vecs [6];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Number of 16-byte DDR words covered by the burst's byte range.
    function automatic int num_words(input logic [31:0] addr, input int len);
        int off;
        off = int'(addr[3:0]) & 14;
        return (off + 2 * (len + 1) + 15) / 16;
    endfunction

    // Expected content of DDR word k: byte j of the word sits at burst byte offset 16k+j-off.
    task automatic model_word(input logic [31:0] addr, input int len, input int k,
                              output logic [127:0] d, output logic [15:0] s);
        int off;
        int pos;
        off = int'(addr[3:0]) & 14;
        d = '0;
        s = '0;
        for (int j = 0; j < 16; j++) begin
            pos = 16 * k + j - off;
            if (pos >= 0 && pos < 2 * (len + 1)) begin
                d[8*j +: 8] = (pos % 2 == 1) ? beat_data[pos/2][15:8] : beat_data[pos/2][7:0];
                s[j]        = beat_strb[pos/2][pos%2];
            end
        end
    endtask

    task automatic drive_w(input int len, input bit gaps);
        int i;
        int guard;
        bit chg;
        i = 0;
        guard = 0;
        chg = 1'b1;
        while (i <= len && guard < 2000) begin
            @(posedge clk); #1;
            if (chg) begin
                s_wvalid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
                s_wdata  = beat_data[i];
                s_wstrb  = beat_strb[i];
            end
            @(negedge clk);
            chg = !s_wvalid || s_wready;
            if (s_wvalid && s_wready) i++;
            guard++;
        end
        chk("upstream beats accepted", i, len + 1);
        repeat (2) begin
            @(posedge clk); #1;
            s_wvalid = 1'b1;
            s_wdata  = 16'hBEEF;
            s_wstrb  = 2'b11;
            @(negedge clk);
            chk("s_wready beyond burst", s_wready, 1'b0);
        end
        @(posedge clk); #1;
        s_wvalid = 1'b0;
    endtask

    task automatic sink_w(input int wmode);
        int    guard;
        int    hold;
        bit    seen_last;
        bit    pend;
        word_t prev;
        word_t cur;
        guard = 0;
        hold = 0;
        seen_last = 1'b0;
        pend = 1'b0;
        prev = '{default: '0};
        while (!seen_last && guard < 3000) begin
            @(posedge clk); #1;
            if (wmode == 0) m_wready = 1'b1;
            else if (wmode == 1) m_wready = ($urandom_range(0, 2) != 0);
            else if (m_wvalid && hold < 5) begin
                m_wready = 1'b0;
                hold++;
            end else m_wready = 1'b1;
            @(negedge clk);
            cur.d = m_wdata;
            cur.s = m_wstrb;
            cur.l = m_wlast;
            if (pend) begin
                chk("m_wvalid held", m_wvalid, 1'b1);
                chk("m_wdata stable", cur.d, prev.d);
                chk("m_wstrb stable", cur.s, prev.s);
                chk("m_wlast stable", cur.l, prev.l);
            end
            if (m_wvalid && !m_wready) chk("s_wready while word pending", s_wready, 1'b0);
            if (m_wvalid && m_wready) begin
                obs_q.push_back(cur);
                if (m_wlast) seen_last = 1'b1;
            end
            pend = m_wvalid && !m_wready;
            prev = cur;
            guard++;
        end
        chk("wlast seen", seen_last, 1'b1);
        @(posedge clk); #1;
        m_wready = 1'b0;
    endtask

    task automatic run_burst(input logic [31:0] addr, input int len, input logic [3:0] id,
                             input logic [1:0] bresp, input int wmode, input bit gaps,
                             input int bdelay);
        int           nw;
        int           guard;
        bit           got;
        logic [127:0] ed;
        logic [15:0]  es;
        nw = num_words(addr, len);
        obs_q.delete();
        @(posedge clk); #1;
        s_awaddr  = addr;
        s_awlen   = 4'(len);
        s_awid    = id;
        s_awvalid = 1'b1;
        @(negedge clk);
        chk("s_awready idle", s_awready, 1'b1);
        @(posedge clk); #1;
        s_awvalid = 1'b0;
        s_awaddr  = '0;
        s_awlen   = '0;
        s_awid    = '0;
        s_wvalid  = 1'b1;
        s_wdata   = 16'hA5A5;
        s_wstrb   = 2'b11;
        @(negedge clk);
        obs_awaddr = m_awaddr;
        obs_awlen  = m_awlen;
        chk("m_awvalid", m_awvalid, 1'b1);
        chk("m_awaddr", m_awaddr, addr & 32'hFFFF_FFF0);
        chk("m_awlen", m_awlen, nw - 1);
        chk("s_wready in addr phase", s_wready, 1'b0);
        chk("s_awready in addr phase", s_awready, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("m_awvalid held", m_awvalid, 1'b1);
        chk("m_awaddr held", m_awaddr, addr & 32'hFFFF_FFF0);
        @(posedge clk); #1;
        m_awready = 1'b1;
        @(posedge clk); #1;
        m_awready = 1'b0;
        s_wvalid  = 1'b0;
        @(negedge clk);
        chk("m_awvalid after handshake", m_awvalid, 1'b0);
        fork
            drive_w(len, gaps);
            sink_w(wmode);
        join
        chk("ddr word count", obs_q.size(), nw);
        for (int k = 0; k < nw && k < obs_q.size(); k++) begin
            model_word(addr, len, k, ed, es);
            chk("m_wdata", obs_q[k].d, ed);
            chk("m_wstrb", obs_q[k].s, es);
            chk("m_wlast", obs_q[k].l, (k == nw - 1));
        end
        @(posedge clk); #1;
        m_bvalid = 1'b1;
        m_bresp  = bresp;
        got = 1'b0;
        guard = 0;
        while (!got && guard < 50) begin
            @(negedge clk);
            got = m_bready;
            if (!got) begin
                @(posedge clk); #1;
            end
            guard++;
        end
        chk("m_bready", got, 1'b1);
        @(posedge clk); #1;
        m_bvalid = 1'b0;
        m_bresp  = 2'b00;
        @(negedge clk);
        chk("s_bvalid", s_bvalid, 1'b1);
        chk("s_bresp", s_bresp, bresp);
        chk("s_bid", s_bid, id);
        chk("m_bready while response pending", m_bready, 1'b0);
        repeat (bdelay) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("s_bvalid held", s_bvalid, 1'b1);
            chk("s_bresp held", s_bresp, bresp);
            chk("s_bid held", s_bid, id);
        end
        @(posedge clk); #1;
        s_bready = 1'b1;
        @(posedge clk); #1;
        s_bready = 1'b0;
        @(negedge clk);
        chk("s_bvalid after handshake", s_bvalid, 1'b0);
        chk("s_awready back in idle", s_awready, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{32'h0000_1000, 7, 4'h1, 2'b00, 0, 0, 32'h0000_1000, 4'd0, 1, 16'hFFFF, 16'hFFFF,
                    128'h0007_0006_0005_0004_0003_0002_0001_0000};
        vecs[1] = '{32'h0000_1006, 3, 4'h2, 2'b00, 0, 0, 32'h0000_1000, 4'd0, 1, 16'h3FC0, 16'h3FC0,
                    128'h0000_0003_0002_0001_0000_0000_0000_0000};
        vecs[2] = '{32'h0000_100E, 15, 4'h3, 2'b01, 0, 1, 32'h0000_1000, 4'd2, 3, 16'hC000, 16'h3FFF,
                    128'h0};
        vecs[3] = '{32'h0000_100E, 15, 4'h4, 2'b00, 2, 0, 32'h0000_1000, 4'd2, 3, 16'hC000, 16'h3FFF,
                    128'h0};
        vecs[4] = '{32'h0000_2000, 1, 4'h5, 2'b10, 0, 3, 32'h0000_2000, 4'd0, 1, 16'h000F, 16'h000F,
                    128'h0000_0000_0000_0000_0000_0000_0001_0000};
        vecs[5] = '{32'h0000_100F, 0, 4'h9, 2'b11, 0, 0, 32'h0000_1000, 4'd0, 1, 16'hC000, 16'hC000,
                    128'h0};

        reset = 1'b1;
        s_awaddr = '0; s_awlen = '0; s_awid = '0; s_awvalid = 1'b0;
        s_wdata = '0; s_wstrb = '0; s_wvalid = 1'b0; s_bready = 1'b0;
        m_awready = 1'b0; m_wready = 1'b0; m_bresp = 2'b00; m_bvalid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset s_awready", s_awready, 1'b0);
        chk("reset s_wready", s_wready, 1'b0);
        chk("reset m_bready", m_bready, 1'b0);
        chk("reset valids", {m_awvalid, m_wvalid, s_bvalid, m_wlast}, 4'b0000);
        chk("reset m_wdata", m_wdata, 128'd0);
        chk("reset m_wstrb", m_wstrb, 16'd0);
        chk("reset m_awaddr", m_awaddr, 32'd0);
        chk("reset m_awlen", m_awlen, 4'd0);
        chk("reset s_bid/s_bresp", {s_bid, s_bresp}, 6'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("idle s_awready", s_awready, 1'b1);

        // Directed table: beat i carries data i with both bytes enabled.
        for (int v = 0; v < 6; v++) begin
            for (int b = 0; b < 16; b++) begin
                beat_data[b] = 16'(b);
                beat_strb[b] = 2'b11;
            end
            run_burst(vecs[v].addr, vecs[v].len, vecs[v].id, vecs[v].bresp,
                      vecs[v].wmode, 1'b0, vecs[v].bdelay);
            chk("table m_awaddr", obs_awaddr, vecs[v].exp_awaddr);
            chk("table m_awlen", obs_awlen, vecs[v].exp_awlen);
            chk("table word count", obs_q.size(), vecs[v].exp_nw);
            if (obs_q.size() == vecs[v].exp_nw) begin
                chk("table first strb", obs_q[0].s, vecs[v].exp_strb0);
                chk("table first data", obs_q[0].d, vecs[v].exp_data0);
                chk("table last strb", obs_q[obs_q.size()-1].s, vecs[v].exp_strbn);
            end
        end

        // Reset after three beats of a burst abandons it.
        for (int b = 0; b < 16; b++) begin
            beat_data[b] = 16'(b);
            beat_strb[b] = 2'b11;
        end
        @(posedge clk); #1;
        s_awaddr = 32'h0000_1000; s_awlen = 4'd7; s_awid = 4'h6; s_awvalid = 1'b1; m_awready = 1'b1;
        @(posedge clk); #1;
        s_awvalid = 1'b0;
        @(posedge clk); #1;
        m_awready = 1'b0; s_wvalid = 1'b1; s_wdata = 16'h0000; s_wstrb = 2'b11;
        @(posedge clk); #1;
        s_wdata = 16'h0001;
        @(posedge clk); #1;
        s_wdata = 16'h0002;
        @(negedge clk);
        chk("s_wready mid-burst", s_wready, 1'b1);
        @(posedge clk); #1;
        s_wvalid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("readies under reset", {s_awready, s_wready, m_bready}, 3'b000);
        @(posedge clk); #1;
        @(negedge clk);
        chk("valids after mid-burst reset", {m_awvalid, m_wvalid, s_bvalid}, 3'b000);
        chk("m_wstrb after mid-burst reset", m_wstrb, 16'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("no output from abandoned burst", {m_awvalid, m_wvalid, s_bvalid}, 3'b000);
            @(posedge clk); #1;
        end
        for (int b = 0; b < 16; b++) begin
            beat_data[b] = 16'($urandom);
            beat_strb[b] = 2'($urandom);
        end
        run_burst(32'h0000_3008, 1, 4'h7, 2'b00, 0, 1'b0, 0);

        // Random bursts with upstream gaps and downstream backpressure.
        for (int r = 0; r < 25; r++) begin
            for (int b = 0; b < 16; b++) begin
                beat_data[b] = 16'($urandom);
                beat_strb[b] = 2'($urandom);
            end
            run_burst($urandom, $urandom_range(0, 15), 4'($urandom), 2'($urandom),
                      1, 1'b1, $urandom_range(0, 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
